// File: rtl/seven_segment_scan.sv
// seven_segment_scan
// ------------------
// Time-multiplexed driver for a NUM_DIGITS seven-segment display.
//
// The load strobe captures a packed hex value, a per-digit blank mask and the
// leading-zero-blanking enable into shadow registers. A prescaler produces one
// refresh tick every REFRESH_DIV cycles. Each tick moves the scan to the next
// digit. A blink counter driven by the ticks toggles a blink phase every
// BLINK_TICKS ticks while blink_en is high.
//
// All outputs are registered. They are computed from the state held before
// the edge, so seg_out and dig_sel always change together.
//
// Ports:
//   clk         in   system clock, all state on the rising edge
//   rst         in   synchronous active-high reset
//   load        in   single-cycle strobe, captures value_in/blank_mask/lzb_en
//   value_in    in   packed nibbles, digit 0 in bits [3:0]
//   blank_mask  in   bit i = 1 forces digit i dark
//   lzb_en      in   leading-zero blanking enable
//   blink_en    in   live blink enable (not latched)
//   seg_out     out  segments {g,f,e,d,c,b,a}, active-low
//   dig_sel     out  digit enables, active-low, one-hot-low after reset
//   tick        out  one-cycle pulse at each digit advance
module seven_segment_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic                      lzb_en,
    input  logic                      blink_en,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      tick
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    localparam logic [6:0] SEG_DARK = 7'b1111111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   mask_q,  mask_d;
    logic                    lzb_q,   lzb_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q,   idx_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q,  blink_ph_d;
    logic [6:0]              seg_q,   seg_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                    tick_q,  tick_d;

    // ------------------------------------------------------------------
    // Per-digit helpers
    // ------------------------------------------------------------------
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] upper_zero;   // bit i: nibbles i..NUM_DIGITS-1 all zero

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]       = value_q[4*gi +: 4];
            assign nib_zero[gi]  = (value_q[4*gi +: 4] == 4'h0);
            assign dig_sel_d[gi] = (idx_q != IDX_W'(gi));
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign upper_zero[gi] = nib_zero[gi];
            end else begin : g_chain
                assign upper_zero[gi] = nib_zero[gi] & upper_zero[gi+1];
            end
        end
    endgenerate

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;   // 4'hF
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic terminal;
    logic dark;

    always_comb begin
        terminal = (presc_q == PRESC_LAST);

        value_d = value_q;
        mask_d  = mask_q;
        lzb_d   = lzb_q;
        if (load) begin
            value_d = value_in;
            mask_d  = blank_mask;
            lzb_d   = lzb_en;
        end

        presc_d = terminal ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Blink state is parked at zero whenever blinking is off, so a new
        // blink_en always starts with a full visible half-period.
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (terminal) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Digit 0 is never leading-zero blanked so an all-zero value shows "0".
        dark = mask_q[idx_q]
             | (lzb_q & (idx_q != '0) & upper_zero[idx_q])
             | (blink_en & blink_ph_q);

        seg_d  = dark ? SEG_DARK : hex_decode(nib[idx_q]);
        tick_d = terminal;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q     <= '0;
            mask_q      <= '0;
            lzb_q       <= 1'b0;
            presc_q     <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= SEG_DARK;
            dig_sel_q   <= '1;
            tick_q      <= 1'b0;
        end else begin
            value_q     <= value_d;
            mask_q      <= mask_d;
            lzb_q       <= lzb_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            dig_sel_q   <= dig_sel_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = dig_sel_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   value_in;
    logic [3:0]    blank_mask;
    logic          lzb_en;
    logic          blink_en;
    logic [6:0]    seg_out;
    logic [3:0]    dig_sel;
    logic          tick;

    int total = 0;
    int bad   = 0;

    seven_segment_scan #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(4),
        .BLINK_TICKS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value_in  (value_in),
        .blank_mask(blank_mask),
        .lzb_en    (lzb_en),
        .blink_en  (blink_en),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  mask;
        logic        lzb;
        int          digit;
        logic [6:0]  exp_seg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] v, input logic [3:0] m, input logic l,
                       input int d, input logic [6:0] s);
        vec_t r;
        r.value = v; r.mask = m; r.lzb = l; r.digit = d; r.exp_seg = s;
        vecs.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("ok   %s act=%h", name, act);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic l);
        value_in = v; blank_mask = m; lzb_en = l; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Steps at least once, then until digit d is being driven (bounded).
    task automatic wait_digit(input int d, output logic found);
        logic [3:0] want;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (dig_sel === want) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL wait_digit%0d timeout dig_sel=%b exp=%b", d, dig_sel, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       found;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        int         d;
        logic [6:0] mask_tab [4];

        // {value, mask, lzb, digit, expected seg}
        add(16'h0123, 4'h0, 1'b0, 0, 7'b0110000);
        add(16'h0123, 4'h0, 1'b0, 1, 7'b0100100);
        add(16'h0123, 4'h0, 1'b0, 2, 7'b1111001);
        add(16'h0123, 4'h0, 1'b0, 3, 7'b1000000);
        add(16'h4567, 4'h0, 1'b0, 0, 7'b1111000);
        add(16'h4567, 4'h0, 1'b0, 1, 7'b0000010);
        add(16'h4567, 4'h0, 1'b0, 2, 7'b0010010);
        add(16'h4567, 4'h0, 1'b0, 3, 7'b0011001);
        add(16'h89AB, 4'h0, 1'b0, 0, 7'b0000011);
        add(16'h89AB, 4'h0, 1'b0, 1, 7'b0001000);
        add(16'h89AB, 4'h0, 1'b0, 2, 7'b0010000);
        add(16'h89AB, 4'h0, 1'b0, 3, 7'b0000000);
        add(16'hCDEF, 4'h0, 1'b0, 0, 7'b0001110);
        add(16'hCDEF, 4'h0, 1'b0, 1, 7'b0000110);
        add(16'hCDEF, 4'h0, 1'b0, 2, 7'b0100001);
        add(16'hCDEF, 4'h0, 1'b0, 3, 7'b1000110);
        add(16'h0050, 4'h0, 1'b1, 0, 7'b1000000);
        add(16'h0050, 4'h0, 1'b1, 1, 7'b0010010);
        add(16'h0050, 4'h0, 1'b1, 2, 7'b1111111);
        add(16'h0050, 4'h0, 1'b1, 3, 7'b1111111);
        add(16'h0000, 4'h0, 1'b1, 0, 7'b1000000);
        add(16'h0000, 4'h0, 1'b1, 1, 7'b1111111);
        add(16'h0000, 4'h0, 1'b1, 2, 7'b1111111);
        add(16'h0000, 4'h0, 1'b1, 3, 7'b1111111);
        add(16'h1234, 4'h4, 1'b0, 0, 7'b0011001);
        add(16'h1234, 4'h4, 1'b0, 1, 7'b0110000);
        add(16'h1234, 4'h4, 1'b0, 2, 7'b1111111);
        add(16'h1234, 4'h4, 1'b0, 3, 7'b1111001);
        add(16'h1000, 4'h0, 1'b1, 2, 7'b1000000);   // zero below a non-zero digit stays lit

        mask_tab[0] = 7'b0011001;
        mask_tab[1] = 7'b0110000;
        mask_tab[2] = 7'b1111111;
        mask_tab[3] = 7'b1111001;

        rst = 1'b1; load = 1'b0; value_in = '0; blank_mask = '0;
        lzb_en = 1'b0; blink_en = 1'b0;

        // Reset state
        step(); step();
        check("rst_seg",  {25'd0, seg_out}, {25'd0, 7'b1111111});
        check("rst_dig",  {28'd0, dig_sel}, {28'd0, 4'b1111});
        check("rst_tick", {31'd0, tick},    32'd0);

        // Scan after release: 4 cycles per digit, tick every 4th edge
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_dig = ~(4'b0001 << (((k - 1) / 4) % 4));
            check($sformatf("scan_dig_k%0d", k),  {28'd0, dig_sel}, {28'd0, exp_dig});
            check($sformatf("scan_tick_k%0d", k), {31'd0, tick}, {31'd0, (k % 4 == 0)});
            check($sformatf("scan_seg_k%0d", k),  {25'd0, seg_out}, {25'd0, 7'b1000000});
        end

        // Table-driven decode / blanking
        foreach (vecs[i]) begin
            do_load(vecs[i].value, vecs[i].mask, vecs[i].lzb);
            wait_digit(vecs[i].digit, found);
            if (found)
                check($sformatf("vec%0d_%h_d%0d", i, vecs[i].value, vecs[i].digit),
                      {25'd0, seg_out}, {25'd0, vecs[i].exp_seg});
        end

        // Load latency: load at edge N, new data visible at N+1
        do_load(16'h0000, 4'h0, 1'b0);
        step(); step();
        value_in = 16'h1234; blank_mask = 4'b0100; lzb_en = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        check("lat_old_seg", {25'd0, seg_out}, {25'd0, 7'b1000000});
        step();
        d = -1;
        for (int b = 0; b < 4; b++) if (dig_sel === ~(4'b0001 << b)) d = b;
        if (d < 0) begin
            check("lat_onecold", {28'd0, dig_sel}, 32'hE);
        end else begin
            check($sformatf("lat_new_seg_d%0d", d), {25'd0, seg_out}, {25'd0, mask_tab[d]});
        end

        // Blink: 8 visible, 8 dark, repeating; dig_sel keeps scanning
        do_load(16'h0000, 4'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick === 1'b1) found = 1'b1;
        end
        check("blink_sync_tick", {31'd0, found}, 32'd1);
        blink_en = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            exp_seg = ((((i - 1) / 8) % 2) == 0) ? 7'b1000000 : 7'b1111111;
            check($sformatf("blink_seg_i%0d", i), {25'd0, seg_out}, {25'd0, exp_seg});
            check($sformatf("blink_dig_i%0d", i), $countones(~dig_sel), 32'd1);
        end
        blink_en = 1'b0;       // falling during a dark phase
        step();
        check("blink_off_seg", {25'd0, seg_out}, {25'd0, 7'b1000000});

        // Reset in the middle of the scan
        do_load(16'hFFFF, 4'h0, 1'b0);
        wait_digit(2, found);
        if (found) check("pre_rst_seg", {25'd0, seg_out}, {25'd0, 7'b0001110});
        rst = 1'b1;
        step();
        check("mid_rst_seg",  {25'd0, seg_out}, {25'd0, 7'b1111111});
        check("mid_rst_dig",  {28'd0, dig_sel}, {28'd0, 4'b1111});
        check("mid_rst_tick", {31'd0, tick},    32'd0);
        rst = 1'b0;
        step();
        check("post_rst_dig", {28'd0, dig_sel}, {28'd0, 4'b1110});
        check("post_rst_seg", {25'd0, seg_out}, {25'd0, 7'b1000000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
